// File: rtl/systolic_result_drain_pkg.sv
// Shared types and constants for the systolic result drain and its shadow bank.
package systolic_result_drain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } drain_state_e;

  // Matches the accumulator PE output width.
  localparam int DEFAULT_DATA_W = 8;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_result_drain_shadow_bank.sv
// Snapshot register bank: captures every PE slice of acc_bus at once and
// exposes one captured value through an index-selected read port.
module result_shadow_bank
  import systolic_result_drain_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IDX_W  = idx_width(NUM_PE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture_en,
  input  logic [NUM_PE*DATA_W-1:0] acc_bus,
  input  logic [IDX_W-1:0]         rd_index,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] shadow_q [NUM_PE];
  logic [DATA_W-1:0] shadow_d [NUM_PE];

  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      shadow_d[i] = capture_en ? acc_bus[i*DATA_W +: DATA_W] : shadow_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PE; i++) begin
      if (rst) begin
        shadow_q[i] <= '0;
      end else begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  // Compare-based mux stays in range even when NUM_PE is not a power of two.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (rd_index == IDX_W'(i)) begin
        rd_data = shadow_q[i];
      end
    end
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Drains a one-shot snapshot of the accumulator row out over a valid/ready
// stream, one PE value per handshake, then pulses done.
module systolic_result_drain
  import systolic_result_drain_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IDX_W  = idx_width(NUM_PE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_PE*DATA_W-1:0] acc_bus,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_last,
  output logic                     done
);

  drain_state_e      state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic              capture_en;
  logic [DATA_W-1:0] shadow_rd;

  result_shadow_bank #(
    .NUM_PE (NUM_PE),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_shadow_bank (
    .clk        (clk),
    .rst        (rst),
    .capture_en (capture_en),
    .acc_bus    (acc_bus),
    .rd_index   (index_q),
    .rd_data    (shadow_rd)
  );

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    capture_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture_en  = 1'b1;
          state_d     = SEND;
          index_d     = '0;
          out_valid_d = 1'b1;
          out_last_d  = (NUM_PE == 1);
        end
      end
      SEND: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            index_d    = index_q + IDX_W'(1);
            out_last_d = (int'(index_q) == NUM_PE - 2);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        index_d = '0;
      end
      default: begin
        state_d     = IDLE;
        index_d     = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      index_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // busy covers the capture cycle itself, so it includes an accepted start.
  assign busy      = (state_q != IDLE) || capture_en;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? shadow_rd : '0;
  assign out_index = out_valid_q ? index_q : '0;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule
